// File: rtl/gate_selftest.sv
// Self-test sequencer for the six-output two-input gate block.
// Walks {A,B} through 00..11, samples the gate outputs and compares them with golden values.
module gate_selftest #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] cout_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state, w_state_d;
  logic [1:0]       r_vec, w_vec_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [5:0]       r_err, w_err_d;
  logic [3:0]       r_fail, w_fail_d;
  logic             r_pass, w_pass_d;
  logic             r_start_q;
  logic             w_start_rise;
  logic             w_a, w_b;
  logic [5:0]       w_golden;
  logic [5:0]       w_diff;

  // Only a rising edge of start launches a run, so a held button gives one run.
  assign w_start_rise = start & ~r_start_q;

  assign w_a      = r_vec[1];
  assign w_b      = r_vec[0];
  assign w_golden = {~(w_a ^ w_b), w_a ^ w_b, ~(w_a | w_b), ~(w_a & w_b), w_a | w_b, w_a & w_b};
  assign w_diff   = cout_in ^ w_golden;

  always_comb begin
    w_state_d = r_state;
    w_vec_d   = r_vec;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    w_fail_d  = r_fail;
    w_pass_d  = r_pass;
    unique case (r_state)
      StIdle: begin
        if (w_start_rise) begin
          w_state_d = StDrive;
          w_vec_d   = 2'd0;
          w_cnt_d   = '0;
          w_err_d   = '0;
          w_fail_d  = '0;
          w_pass_d  = 1'b0;
        end
      end
      StDrive: begin
        w_cnt_d = r_cnt + CNT_W'(1);
        if (r_cnt == LastCnt) begin
          w_state_d = StSample;
        end
      end
      StSample: begin
        w_err_d         = r_err | w_diff;
        w_fail_d[r_vec] = |w_diff;
        if (r_vec == 2'd3) begin
          w_state_d = StDone;
          // Pass is resolved on entry to DONE so it is valid alongside the done pulse.
          w_pass_d  = (w_err_d == 6'd0);
        end else begin
          w_state_d = StDrive;
          w_vec_d   = r_vec + 2'd1;
          w_cnt_d   = '0;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_vec     <= 2'd0;
      r_cnt     <= '0;
      r_err     <= '0;
      r_fail    <= '0;
      r_pass    <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_vec     <= w_vec_d;
      r_cnt     <= w_cnt_d;
      r_err     <= w_err_d;
      r_fail    <= w_fail_d;
      r_pass    <= w_pass_d;
      r_start_q <= start;
    end
  end

  assign a_out    = r_vec[1];
  assign b_out    = r_vec[0];
  assign busy     = (r_state == StDrive) || (r_state == StSample);
  assign done     = (r_state == StDone);
  assign pass     = r_pass;
  assign err_mask = r_err;
  assign fail_vec = r_fail;

endmodule

// File: tb/tb_gate_selftest.sv
// Directed bench for gate_selftest: a table of faulty gate models plus reset and restart sequences.
module tb_gate_selftest;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] cout_in;
  logic       a_out, b_out, busy, done, pass;
  logic [5:0] err_mask;
  logic [3:0] fail_vec;

  logic [5:0] stuck0;
  logic [5:0] stuck1;

  int n_cmp;
  int n_bad;

  gate_selftest #(
    .HOLD_CYCLES(4),
    .CNT_W      (3)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cout_in (cout_in),
    .a_out   (a_out),
    .b_out   (b_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_mask(err_mask),
    .fail_vec(fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived gate outputs, bit order XNOR,XOR,NOR,NAND,OR,AND (msb..lsb).
  function automatic logic [5:0] gold(input logic [1:0] v);
    case (v)
      2'b00:   gold = 6'b101100;
      2'b01:   gold = 6'b010110;
      2'b10:   gold = 6'b010110;
      default: gold = 6'b100011;
    endcase
  endfunction

  always_comb cout_in = (gold({a_out, b_out}) & ~stuck0) | stuck1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full run; optionally re-pulses start at sample index restart_at (0 = never).
  task automatic run(input int restart_at, input logic [5:0] exp_err, input logic [3:0] exp_fail,
                     input logic exp_pass);
    int done_at;
    int dones;
    bit ab_ok;
    done_at = 0;
    dones   = 0;
    ab_ok   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("err_cleared_on_start", int'(err_mask), 0);
        check("fail_cleared_on_start", int'(fail_vec), 0);
        check("pass_cleared_on_start", int'(pass), 0);
      end
      if (restart_at != 0 && n == restart_at) start = 1'b1;
      if (restart_at != 0 && n == restart_at + 1) start = 1'b0;
      if (n <= 20 && {a_out, b_out} !== 2'((n - 1) / 5)) ab_ok = 1'b0;
      if (done) begin
        dones++;
        if (done_at == 0) done_at = n;
      end
      if (n == 21) check("busy_low_in_done", int'(busy), 0);
    end
    check("ab_sequence", int'(ab_ok), 1);
    check("done_cycle", done_at, 21);
    check("done_count", dones, 1);
    check("err_mask", int'(err_mask), int'(exp_err));
    check("fail_vec", int'(fail_vec), int'(exp_fail));
    check("pass", int'(pass), int'(exp_pass));
  endtask

  typedef struct {
    logic [5:0] s0;
    logic [5:0] s1;
    logic [5:0] err;
    logic [3:0] fail;
    logic       pass;
  } vec_t;

  vec_t tbl[8];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    stuck0 = 6'd0;
    stuck1 = 6'd0;

    tbl[0] = '{6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b1};  // good gates
    tbl[1] = '{6'b010000, 6'b000000, 6'b010000, 4'b0110, 1'b0};  // XOR stuck 0
    tbl[2] = '{6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b1};  // good after failing run
    tbl[3] = '{6'b000000, 6'b000001, 6'b000001, 4'b0111, 1'b0};  // AND stuck 1
    tbl[4] = '{6'b000010, 6'b000000, 6'b000010, 4'b1110, 1'b0};  // OR stuck 0
    tbl[5] = '{6'b000000, 6'b100000, 6'b100000, 4'b0110, 1'b0};  // XNOR stuck 1
    tbl[6] = '{6'b000000, 6'b000100, 6'b000100, 4'b1000, 1'b0};  // NAND stuck 1
    tbl[7] = '{6'b111111, 6'b000000, 6'b111111, 4'b1111, 1'b0};  // all stuck 0

    repeat (2) @(negedge clk);
    check("reset_outputs", int'({a_out, b_out, busy, done, pass, err_mask, fail_vec}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      stuck0 = tbl[i].s0;
      stuck1 = tbl[i].s1;
      run(0, tbl[i].err, tbl[i].fail, tbl[i].pass);
    end

    // Results hold while idle.
    repeat (5) @(negedge clk);
    check("hold_err", int'(err_mask), 6'b111111);
    check("hold_fail", int'(fail_vec), 4'b1111);

    // Reset in the middle of a run: no done, everything back to zero.
    stuck0 = 6'd0;
    stuck1 = 6'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs",
          int'({a_out, b_out, busy, done, pass, err_mask, fail_vec}), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int dn;
      dn = 0;
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (done || busy) dn++;
      end
      check("no_activity_after_reset", dn, 0);
    end
    run(0, 6'd0, 4'd0, 1'b1);

    // Second start pulse mid-run is ignored.
    stuck0 = 6'b010000;
    run(5, 6'b010000, 4'b0110, 1'b0);

    // Start held high: exactly one run.
    stuck0 = 6'd0;
    begin
      int dn;
      dn = 0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 60; n++) begin
        @(negedge clk);
        if (done) dn++;
      end
      start = 1'b0;
      check("held_start_one_run", dn, 1);
      check("held_start_pass", int'(pass), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
